// File: rtl/ex_mem_pipe_elastic.sv
// EX/MEM elastic stage: main + skid register; accept at edge N is visible on the outputs in cycle N+1.
// Backpressure: in_ready comes only from the state register, and the skid absorbs the single in-flight beat.
module ex_mem_pipe_elastic #(
  parameter int XLEN   = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   read_data_2_ex,
  input  logic [XLEN-1:0]   aluresult_ex,
  input  logic [XLEN-1:0]   result_ex,
  input  logic [REG_W-1:0]  rd_ex,
  input  logic [CTRL_W-1:0] ctrl_ex,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   read_data_2_mem,
  output logic [XLEN-1:0]   aluresult_mem,
  output logic [XLEN-1:0]   result_mem,
  output logic [REG_W-1:0]  rd_mem,
  output logic [CTRL_W-1:0] ctrl_mem,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic [XLEN-1:0]   rs2_dat;
    logic [XLEN-1:0]   alu_dat;
    logic [XLEN-1:0]   res_dat;
    logic [REG_W-1:0]  rd;
    logic [CTRL_W-1:0] ctrl;
  } payload_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t   state_q, state_n;
  payload_t main_q, skid_q, in_pl;
  logic     accept, fire;
  logic     load_main_in, load_main_skid, load_skid;
  logic     clr_main_ctrl, clr_skid_ctrl;

  assign in_pl = '{rs2_dat: read_data_2_ex, alu_dat: aluresult_ex,
                   res_dat: result_ex, rd: rd_ex, ctrl: ctrl_ex};

  // Handshake outputs depend on the state register only.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign occupancy = state_q;
  assign accept    = in_valid & in_ready;
  assign fire      = out_valid & out_ready;

  always_comb begin
    state_n        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    clr_main_ctrl  = 1'b0;
    clr_skid_ctrl  = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_n      = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && fire) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_n   = TWO;
          load_skid = 1'b1;
        end else if (fire) begin
          state_n       = EMPTY;
          clr_main_ctrl = 1'b1;
        end
      end
      TWO: begin
        if (fire) begin
          state_n        = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_n = EMPTY;
    endcase
    // Flush wins over any handshake, including a same-cycle accept.
    if (flush) begin
      state_n        = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      clr_main_ctrl  = 1'b1;
      clr_skid_ctrl  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_n;
      if (load_main_in)        main_q      <= in_pl;
      else if (load_main_skid) main_q      <= skid_q;
      else if (clr_main_ctrl)  main_q.ctrl <= '0;
      if (load_skid)           skid_q      <= in_pl;
      else if (clr_skid_ctrl)  skid_q.ctrl <= '0;
    end
  end

  assign read_data_2_mem = main_q.rs2_dat;
  assign aluresult_mem   = main_q.alu_dat;
  assign result_mem      = main_q.res_dat;
  assign rd_mem          = main_q.rd;
  assign ctrl_mem        = main_q.ctrl;

endmodule

// File: tb/tb_ex_mem_pipe_elastic.sv
// Directed bench for ex_mem_pipe_elastic: default instance plus a wide-parameter instance.
module tb_ex_mem_pipe_elastic;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] rd2_ex, alu_ex, res_ex, rd2_mem, alu_mem, res_mem;
  logic [4:0]  rd_ex, rd_mem;
  logic [6:0]  ctrl_ex, ctrl_mem;
  logic [1:0]  occ;

  logic        w_flush, w_in_valid, w_out_ready, w_in_ready, w_out_valid;
  logic [63:0] w_rd2_ex, w_alu_ex, w_res_ex, w_rd2_mem, w_alu_mem, w_res_mem;
  logic [5:0]  w_rd_ex, w_rd_mem;
  logic [8:0]  w_ctrl_ex, w_ctrl_mem;
  logic [1:0]  w_occ;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_mem_pipe_elastic dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .read_data_2_ex(rd2_ex), .aluresult_ex(alu_ex), .result_ex(res_ex),
    .rd_ex(rd_ex), .ctrl_ex(ctrl_ex), .out_valid(out_valid), .out_ready(out_ready),
    .read_data_2_mem(rd2_mem), .aluresult_mem(alu_mem), .result_mem(res_mem),
    .rd_mem(rd_mem), .ctrl_mem(ctrl_mem), .occupancy(occ)
  );

  ex_mem_pipe_elastic #(.XLEN(64), .REG_W(6), .CTRL_W(9)) dut_w (
    .clk(clk), .rst(rst), .flush(w_flush), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .read_data_2_ex(w_rd2_ex), .aluresult_ex(w_alu_ex), .result_ex(w_res_ex),
    .rd_ex(w_rd_ex), .ctrl_ex(w_ctrl_ex), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .read_data_2_mem(w_rd2_mem), .aluresult_mem(w_alu_mem), .result_mem(w_res_mem),
    .rd_mem(w_rd_mem), .ctrl_mem(w_ctrl_mem), .occupancy(w_occ)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] stream_v [4];

  initial begin
    stream_v[0] = 32'h10; stream_v[1] = 32'h20;
    stream_v[2] = 32'h30; stream_v[3] = 32'h40;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rd2_ex = '0; alu_ex = '0; res_ex = '0; rd_ex = '0; ctrl_ex = '0;
    w_flush = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b0;
    w_rd2_ex = '0; w_alu_ex = '0; w_res_ex = '0; w_rd_ex = '0; w_ctrl_ex = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_occ", {62'd0, occ}, 64'd0);
    chk("rst_ctrl", {57'd0, ctrl_mem}, 64'd0);
    chk("rst_rd", {59'd0, rd_mem}, 64'd0);
    chk("rst_alu", {32'd0, alu_mem}, 64'd0);
    chk("rst_rd2", {32'd0, rd2_mem}, 64'd0);
    chk("rst_res", {32'd0, res_mem}, 64'd0);

    // Streaming with out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; alu_ex = stream_v[i]; rd_ex = 5'(i + 1); ctrl_ex = 7'h10;
      tick();
      chk("stream_valid", {63'd0, out_valid}, 64'd1);
      chk("stream_alu", {32'd0, alu_mem}, {32'd0, stream_v[i]});
      chk("stream_occ", {62'd0, occ}, 64'd1);
      chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("drain_valid", {63'd0, out_valid}, 64'd0);
    chk("drain_ctrl", {57'd0, ctrl_mem}, 64'd0);
    chk("drain_occ", {62'd0, occ}, 64'd0);

    // Backpressure: A in main, B into skid, C held off
    in_valid = 1'b1; alu_ex = 32'h11; ctrl_ex = 7'h10;
    tick();
    chk("bp_A", {32'd0, alu_mem}, 64'h11);
    out_ready = 1'b0; alu_ex = 32'h22;
    tick();
    chk("bp_occ2", {62'd0, occ}, 64'd2);
    chk("bp_in_ready0", {63'd0, in_ready}, 64'd0);
    chk("bp_hold_A1", {32'd0, alu_mem}, 64'h11);
    alu_ex = 32'h33;
    tick();
    chk("bp_hold_A2", {32'd0, alu_mem}, 64'h11);
    chk("bp_occ2b", {62'd0, occ}, 64'd2);
    tick();
    chk("bp_hold_A3", {32'd0, alu_mem}, 64'h11);
    out_ready = 1'b1;
    tick();
    chk("bp_B", {32'd0, alu_mem}, 64'h22);
    chk("bp_occ1", {62'd0, occ}, 64'd1);
    chk("bp_in_ready1", {63'd0, in_ready}, 64'd1);
    tick();
    chk("bp_C", {32'd0, alu_mem}, 64'h33);
    chk("bp_C_occ", {62'd0, occ}, 64'd1);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", {63'd0, out_valid}, 64'd0);

    // Flush while holding two entries, with a competing accept
    out_ready = 1'b0; in_valid = 1'b1; ctrl_ex = 7'h12; alu_ex = 32'h50;
    tick();
    alu_ex = 32'h60;
    tick();
    chk("fl_occ2", {62'd0, occ}, 64'd2);
    chk("fl_ctrl12", {57'd0, ctrl_mem}, 64'h12);
    flush = 1'b1; ctrl_ex = 7'h7F; alu_ex = 32'h70;
    tick();
    chk("fl_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_ctrl", {57'd0, ctrl_mem}, 64'd0);
    chk("fl_occ", {62'd0, occ}, 64'd0);
    chk("fl_in_ready", {63'd0, in_ready}, 64'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("fl_no_7f_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_no_7f_ctrl", {57'd0, ctrl_mem}, 64'd0);

    // Reset while stalled with two entries
    out_ready = 1'b0; in_valid = 1'b1; rd_ex = 5'd5; ctrl_ex = 7'h12;
    alu_ex = 32'h80; rd2_ex = 32'hAA; res_ex = 32'hBB;
    tick(); tick();
    chk("rs_occ2", {62'd0, occ}, 64'd2);
    rst = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
    tick();
    chk("rs_valid", {63'd0, out_valid}, 64'd0);
    chk("rs_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rs_occ", {62'd0, occ}, 64'd0);
    chk("rs_ctrl", {57'd0, ctrl_mem}, 64'd0);
    chk("rs_rd", {59'd0, rd_mem}, 64'd0);
    chk("rs_alu", {32'd0, alu_mem}, 64'd0);
    chk("rs_rd2", {32'd0, rd2_mem}, 64'd0);
    chk("rs_res", {32'd0, res_mem}, 64'd0);
    rst = 1'b0;

    // Accept and fire in the same cycle
    in_valid = 1'b1; rd_ex = 5'd3; ctrl_ex = 7'h10; out_ready = 1'b1;
    tick();
    chk("af_rd3", {59'd0, rd_mem}, 64'd3);
    rd_ex = 5'd9;
    tick();
    chk("af_rd9", {59'd0, rd_mem}, 64'd9);
    chk("af_occ", {62'd0, occ}, 64'd1);
    in_valid = 1'b0;
    tick();

    // Wide parameter set, all-ones payload
    w_in_valid = 1'b1; w_rd2_ex = '1; w_alu_ex = '1; w_res_ex = '1;
    w_rd_ex = '1; w_ctrl_ex = '1;
    tick();
    chk("w_valid", {63'd0, w_out_valid}, 64'd1);
    chk("w_occ", {62'd0, w_occ}, 64'd1);
    chk("w_rd2", w_rd2_mem, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("w_alu", w_alu_mem, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("w_res", w_res_mem, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("w_rd", {58'd0, w_rd_mem}, 64'h3F);
    chk("w_ctrl", {55'd0, w_ctrl_mem}, 64'h1FF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
